// File: rtl/synth_pkg.sv
// Shared constants and FSM state type for the voice allocator.
package synth_pkg;

  localparam int NUM_VOICES = 4;
  localparam int FREQ_W     = 12;
  localparam int KEY_W      = 7;
  localparam int AGE_W      = 8;
  localparam int unsigned AGE_MAX = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    ASSIGN = 2'd2
  } state_t;

endpackage

// File: rtl/voice_slot.sv
// One voice: key/freq/gate/age registers with load, release and age-increment.
module voice_slot #(
  parameter int FREQ_W = synth_pkg::FREQ_W,
  parameter int KEY_W  = synth_pkg::KEY_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_i,
  input  logic [KEY_W-1:0]            load_key_i,
  input  logic [FREQ_W-1:0]           load_freq_i,
  input  logic                        rel_i,
  input  logic [KEY_W-1:0]            rel_key_i,
  input  logic                        age_inc_i,
  output logic                        gate_o,
  output logic [KEY_W-1:0]            key_o,
  output logic [FREQ_W-1:0]           freq_o,
  output logic [synth_pkg::AGE_W-1:0] age_o
);
  import synth_pkg::*;

  logic              gate_q, gate_d;
  logic [KEY_W-1:0]  key_q,  key_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [AGE_W-1:0]  age_q,  age_d;

  // Next state: load beats release so a same-cycle note-off cannot drop a fresh note.
  always_comb begin
    gate_d = gate_q;
    key_d  = key_q;
    freq_d = freq_q;
    age_d  = age_q;
    if (age_inc_i && gate_q && (age_q != AGE_W'(AGE_MAX))) begin
      age_d = age_q + 1'b1;
    end
    if (rel_i && (key_q == rel_key_i)) begin
      gate_d = 1'b0;
    end
    if (load_i) begin
      gate_d = 1'b1;
      key_d  = load_key_i;
      freq_d = load_freq_i;
      age_d  = '0;
    end
  end

  // Voice state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_q <= 1'b0;
      key_q  <= '0;
      freq_q <= '0;
      age_q  <= '0;
    end else begin
      gate_q <= gate_d;
      key_q  <= key_d;
      freq_q <= freq_d;
      age_q  <= age_d;
    end
  end

  assign gate_o = gate_q;
  assign key_o  = key_q;
  assign freq_o = freq_q;
  assign age_o  = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: serial scan of voices, then assign the chosen victim.
module voice_allocator #(
  parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
  parameter int FREQ_W     = synth_pkg::FREQ_W,
  parameter int KEY_W      = synth_pkg::KEY_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         on_valid,
  output logic                         on_ready,
  input  logic [KEY_W-1:0]             on_key,
  input  logic [FREQ_W-1:0]            on_freq,
  input  logic                         off_valid,
  input  logic [KEY_W-1:0]             off_key,
  output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_retrig,
  output logic                         steal
);
  import synth_pkg::*;

  localparam int IDX_W = $clog2(NUM_VOICES);
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NUM_VOICES - 1);

  state_t            state_q, state_d;
  idx_t              scan_idx_q, scan_idx_d;
  logic [KEY_W-1:0]  lat_key_q, lat_key_d;
  logic [FREQ_W-1:0] lat_freq_q, lat_freq_d;

  // Running scan results: first key match, first free voice, oldest gated voice.
  logic              match_found_q, match_found_d;
  idx_t              match_idx_q, match_idx_d;
  logic              free_found_q, free_found_d;
  idx_t              free_idx_q, free_idx_d;
  logic              best_found_q, best_found_d;
  idx_t              best_idx_q, best_idx_d;
  logic [AGE_W-1:0]  best_age_q, best_age_d;

  logic [KEY_W-1:0]  slot_key  [NUM_VOICES];
  logic [FREQ_W-1:0] slot_freq [NUM_VOICES];
  logic [AGE_W-1:0]  slot_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0] slot_gate;
  logic [NUM_VOICES-1:0] slot_load;
  logic [NUM_VOICES-1:0] slot_age_inc;

  logic              cur_gate;
  logic [KEY_W-1:0]  cur_key;
  logic [AGE_W-1:0]  cur_age;
  logic              in_assign;
  logic              is_steal;
  idx_t              victim;

  // Scan comparator inputs: live state of the voice currently under examination.
  always_comb begin
    cur_gate = slot_gate[scan_idx_q];
    cur_key  = slot_key[scan_idx_q];
    cur_age  = slot_age[scan_idx_q];
  end

  // FSM and scan bookkeeping; strict '>' keeps the lowest index on age ties.
  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    lat_key_d     = lat_key_q;
    lat_freq_d    = lat_freq_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    best_found_d  = best_found_q;
    best_idx_d    = best_idx_q;
    best_age_d    = best_age_q;
    case (state_q)
      IDLE: begin
        if (on_valid) begin
          state_d       = SCAN;
          scan_idx_d    = '0;
          lat_key_d     = on_key;
          lat_freq_d    = on_freq;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          best_found_d  = 1'b0;
        end
      end
      SCAN: begin
        if (cur_gate && (cur_key == lat_key_q) && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = scan_idx_q;
        end
        if (!cur_gate && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = scan_idx_q;
        end
        if (cur_gate && (!best_found_q || (cur_age > best_age_q))) begin
          best_found_d = 1'b1;
          best_idx_d   = scan_idx_q;
          best_age_d   = cur_age;
        end
        if (scan_idx_q == LAST_IDX) begin
          state_d = ASSIGN;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      ASSIGN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and scan-result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      scan_idx_q    <= '0;
      lat_key_q     <= '0;
      lat_freq_q    <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      best_found_q  <= 1'b0;
      best_idx_q    <= '0;
      best_age_q    <= '0;
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      lat_key_q     <= lat_key_d;
      lat_freq_q    <= lat_freq_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      best_found_q  <= best_found_d;
      best_idx_q    <= best_idx_d;
      best_age_q    <= best_age_d;
    end
  end

  // Victim priority: retrigger same key, else first free voice, else steal the oldest.
  always_comb begin
    in_assign = (state_q == ASSIGN);
    if (match_found_q) begin
      victim = match_idx_q;
    end else if (free_found_q) begin
      victim = free_idx_q;
    end else begin
      victim = best_idx_q;
    end
    is_steal = in_assign && !match_found_q && !free_found_q;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      slot_load[v]    = in_assign && (victim == idx_t'(v));
      slot_age_inc[v] = in_assign && (victim != idx_t'(v));
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_slot
    voice_slot #(
      .FREQ_W (FREQ_W),
      .KEY_W  (KEY_W)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (slot_load[v]),
      .load_key_i  (lat_key_q),
      .load_freq_i (lat_freq_q),
      .rel_i       (off_valid),
      .rel_key_i   (off_key),
      .age_inc_i   (slot_age_inc[v]),
      .gate_o      (slot_gate[v]),
      .key_o       (slot_key[v]),
      .freq_o      (slot_freq[v]),
      .age_o       (slot_age[v])
    );
    assign voice_freq[v*FREQ_W +: FREQ_W] = slot_freq[v];
  end

  // Handshake and pulse outputs are masked while reset is held.
  assign on_ready     = rst_n && (state_q == IDLE);
  assign voice_gate   = slot_gate;
  assign voice_retrig = rst_n ? slot_load : '0;
  assign steal        = rst_n && is_steal;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus randomized traffic
// checked every cycle against a behavioural allocation model.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int FW = 12;
  localparam int KW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          on_valid = 1'b0;
  logic [KW-1:0] on_key = '0;
  logic [FW-1:0] on_freq = '0;
  logic          off_valid = 1'b0;
  logic [KW-1:0] off_key = '0;
  logic          on_ready;
  logic [NV*FW-1:0] voice_freq;
  logic [NV-1:0] voice_gate;
  logic [NV-1:0] voice_retrig;
  logic          steal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  voice_allocator #(
    .NUM_VOICES (NV),
    .FREQ_W     (FW),
    .KEY_W      (KW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .on_valid     (on_valid),
    .on_ready     (on_ready),
    .on_key       (on_key),
    .on_freq      (on_freq),
    .off_valid    (off_valid),
    .off_key      (off_key),
    .voice_freq   (voice_freq),
    .voice_gate   (voice_gate),
    .voice_retrig (voice_retrig),
    .steal        (steal)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase 0 = waiting for a request, 1..NV = voice phase-1 is observed, NV+1 = assignment.
  bit m_gate [NV];
  int m_key  [NV];
  int m_freq [NV];
  int m_age  [NV];
  bit s_gate [NV];
  int s_key  [NV];
  int s_age  [NV];
  int phase = 0;
  int lk = 0;
  int lf = 0;
  bit started = 0;

  function automatic void pick(output int vic, output bit stl);
    vic = -1;
    stl = 1'b0;
    for (int i = 0; i < NV; i++)
      if (vic < 0 && s_gate[i] && s_key[i] == lk) vic = i;
    if (vic < 0)
      for (int i = 0; i < NV; i++)
        if (vic < 0 && !s_gate[i]) vic = i;
    if (vic < 0) begin
      vic = 0;
      for (int i = 1; i < NV; i++)
        if (s_age[i] > s_age[vic]) vic = i;
      stl = 1'b1;
    end
  endfunction

  always @(posedge clk) begin : model
    int vic;
    bit stl;
    bit ng [NV];
    if (!rst_n) begin
      started = 1;
      phase = 0;
      for (int i = 0; i < NV; i++) begin
        m_gate[i] = 0; m_key[i] = 0; m_freq[i] = 0; m_age[i] = 0;
      end
    end else begin
      vic = -1;
      if (phase >= 1 && phase <= NV) begin
        s_gate[phase-1] = m_gate[phase-1];
        s_key[phase-1]  = m_key[phase-1];
        s_age[phase-1]  = m_age[phase-1];
      end
      if (phase == NV + 1) pick(vic, stl);
      for (int i = 0; i < NV; i++) begin
        ng[i] = m_gate[i];
        if (off_valid && m_key[i] == int'(off_key)) ng[i] = 0;
      end
      if (phase == NV + 1)
        for (int i = 0; i < NV; i++)
          if (i != vic && m_gate[i]) m_age[i] = (m_age[i] < 255) ? m_age[i] + 1 : 255;
      for (int i = 0; i < NV; i++) m_gate[i] = ng[i];
      if (vic >= 0) begin
        m_gate[vic] = 1; m_key[vic] = lk; m_freq[vic] = lf; m_age[vic] = 0;
      end
      if (phase == 0) begin
        if (on_valid) begin
          lk = int'(on_key);
          lf = int'(on_freq);
          phase = 1;
        end
      end else if (phase <= NV) begin
        phase = phase + 1;
      end else begin
        phase = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    int v;
    bit s;
    logic [NV-1:0] eg;
    logic [NV-1:0] er;
    logic [NV*FW-1:0] ef;
    logic es;
    if (started) begin
      er = '0;
      es = 1'b0;
      if (phase == NV + 1 && rst_n) begin
        pick(v, s);
        er[v] = 1'b1;
        es = s;
      end
      for (int i = 0; i < NV; i++) begin
        eg[i] = m_gate[i];
        ef[i*FW +: FW] = FW'(m_freq[i]);
      end
      chk("on_ready", 64'(on_ready), 64'(rst_n && phase == 0));
      chk("voice_gate", 64'(voice_gate), 64'(eg));
      chk("voice_freq", 64'(voice_freq), 64'(ef));
      chk("voice_retrig", 64'(voice_retrig), 64'(er));
      chk("steal", 64'(steal), 64'(es));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; on_valid = 1'b0; off_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("reset_ready", 64'(on_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_gate", 64'(voice_gate), 64'd0);
    chk("reset_retrig", 64'(voice_retrig), 64'd0);
    chk("reset_steal", 64'(steal), 64'd0);
    chk("post_reset_ready", 64'(on_ready), 64'd1);
    @(posedge clk); #2;
  endtask

  // Issue one note-on; report accept-to-retrig latency, retrig vector and steal.
  task automatic do_on(input int k, input int f, output int lat,
                       output logic [NV-1:0] rt, output logic st);
    int n;
    n = 0;
    while (!on_ready && n < 50) begin @(posedge clk); #2; n++; end
    if (!on_ready) chk("ready_wait", 64'd0, 64'd1);
    on_valid = 1'b1; on_key = KW'(k); on_freq = FW'(f);
    @(posedge clk); #2;
    on_valid = 1'b0;
    lat = 1;
    while (voice_retrig == '0 && lat < 40) begin @(posedge clk); #2; lat++; end
    rt = voice_retrig;
    st = steal;
    @(posedge clk); #2;
  endtask

  task automatic do_off(input int k);
    off_valid = 1'b1; off_key = KW'(k);
    @(posedge clk); #2;
    off_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    logic [NV-1:0] rt;
    logic st;
    int keys [5];
    int frqs [5];
    keys = '{60, 64, 67, 72, 76};
    frqs = '{440, 554, 659, 880, 1047};

    // Single note lands in voice 0 with NV+1 latency.
    do_reset();
    do_on(60, 440, lat, rt, st);
    chk("lat_first", 64'(lat), 64'd5);
    chk("retrig_first", 64'(rt), 64'b0001);
    chk("steal_first", 64'(st), 64'd0);
    chk("gate_first", 64'(voice_gate), 64'b0001);
    chk("freq0_first", 64'(voice_freq[FW-1:0]), 64'd440);

    // Fill all voices, fifth note steals the oldest (voice 0).
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_on(keys[i], frqs[i], lat, rt, st);
      chk("fill_retrig", 64'(rt), 64'(1 << i));
      chk("fill_steal", 64'(st), 64'd0);
    end
    do_on(keys[4], frqs[4], lat, rt, st);
    chk("steal_retrig", 64'(rt), 64'b0001);
    chk("steal_pulse", 64'(st), 64'd1);
    chk("steal_freq0", 64'(voice_freq[FW-1:0]), 64'd1047);
    chk("steal_gate", 64'(voice_gate), 64'b1111);

    // Release frees a voice whose freq is held; next note reuses it.
    do_reset();
    for (int i = 0; i < 3; i++) do_on(keys[i], frqs[i], lat, rt, st);
    do_off(64);
    chk("off_gate", 64'(voice_gate), 64'b0101);
    chk("off_freq1", 64'(voice_freq[2*FW-1:FW]), 64'd554);
    do_on(79, 1568, lat, rt, st);
    chk("reuse_retrig", 64'(rt), 64'b0010);
    chk("reuse_freq1", 64'(voice_freq[2*FW-1:FW]), 64'd1568);

    // Same key twice retriggers the same voice.
    do_reset();
    do_on(60, 440, lat, rt, st);
    do_on(60, 440, lat, rt, st);
    chk("same_key_retrig", 64'(rt), 64'b0001);
    chk("same_key_steal", 64'(st), 64'd0);
    chk("same_key_gate", 64'(voice_gate), 64'b0001);

    // Note-off in the assignment cycle loses to the assignment.
    do_reset();
    on_valid = 1'b1; on_key = KW'(60); on_freq = FW'(440);
    @(posedge clk); #2;
    on_valid = 1'b0;
    n = 0;
    while (voice_retrig == '0 && n < 40) begin @(posedge clk); #2; n++; end
    chk("assign_off_retrig", 64'(voice_retrig), 64'b0001);
    do_off(60);
    chk("assign_off_gate", 64'(voice_gate), 64'b0001);

    // Reset during scan aborts the allocation.
    do_reset();
    on_valid = 1'b1; on_key = KW'(60); on_freq = FW'(440);
    @(posedge clk); #2;
    on_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    chk("abort_retrig", 64'(voice_retrig), 64'd0);
    chk("abort_gate", 64'(voice_gate), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("abort_ready", 64'(on_ready), 64'd1);
    chk("abort_retrig2", 64'(voice_retrig), 64'd0);
    do_on(60, 440, lat, rt, st);
    chk("abort_next_retrig", 64'(rt), 64'b0001);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      rst_n     = ($urandom_range(0, 499) != 0);
      on_valid  = ($urandom_range(0, 2) == 0);
      on_key    = KW'(60 + $urandom_range(0, 7));
      on_freq   = FW'($urandom);
      off_valid = ($urandom_range(0, 4) == 0);
      off_key   = KW'(60 + $urandom_range(0, 7));
    end
    @(posedge clk); #2;
    rst_n = 1'b1; on_valid = 1'b0; off_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
